fetch_unit: RTL

//  Instruction fetch stage directly upstream of the control decoder.
//  - Owns the PC; issues word requests to instruction memory over a req/gnt + rvalid bus.
//  - Buffers returned instructions in an in-order FIFO and presents inst/inst_pc/pc_plus4
//    to decode with a valid/ready handshake.
//  - Applies PCSel redirects (branch/JAL/JALR target from the ALU) and flushes wrong-path fetches.

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/gnt bus, in-order instruction FIFO
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky fetch_misalign trap on misaligned redirect).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel,
  input  logic [31:0] alu_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] drop, drop_nxt;
  logic [CW-1:0] fifo_count, fifo_count_nxt;
  logic [PW-1:0] fifo_wr, fifo_rd, tag_wr, tag_rd;
  logic          req_nxt;
  logic          halted, halted_nxt;

  logic [31:0]   fifo_inst [BUF_DEPTH];
  logic [31:0]   fifo_pc   [BUF_DEPTH];
  logic [31:0]   tag_pc    [BUF_DEPTH];

  logic req_fire, pop, push, redirect;

  assign req_fire = imem_req & imem_gnt;
  assign pop      = inst_valid & inst_ready;
  assign redirect = pop & pc_sel;
  assign push     = imem_rvalid & (state == RUN) & ~halted;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign halted     = fetch_misalign;
  assign halted_nxt = fetch_misalign | (redirect & (alu_target[1:0] != 2'b00));
`else
  assign halted     = 1'b0;
  assign halted_nxt = 1'b0;
`endif

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !imem_rvalid)
      outstanding_nxt = outstanding + CW'(1);
    else if (!req_fire && imem_rvalid)
      outstanding_nxt = outstanding - CW'(1);

    fetch_pc_nxt   = req_fire ? fetch_pc + 32'd4 : fetch_pc;
    fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);
    drop_nxt       = drop;
    state_nxt      = state;

    if (state == FLUSH && imem_rvalid) begin
      drop_nxt = drop - CW'(1);
      if (drop == CW'(1))
        state_nxt = RUN;
    end

    // A redirect also voids this cycle's push and counts this cycle's gnt as wrong-path.
    if (redirect) begin
      fetch_pc_nxt   = alu_target & 32'hFFFF_FFFC;
      fifo_count_nxt = '0;
      drop_nxt       = outstanding_nxt;
      state_nxt      = (outstanding_nxt != '0) ? FLUSH : RUN;
    end

    req_nxt = (state_nxt == RUN) && !halted_nxt &&
              (({1'b0, outstanding_nxt} + {1'b0, fifo_count_nxt}) < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      imem_req    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      fifo_count  <= fifo_count_nxt;
      imem_req    <= req_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misalign <= halted_nxt;
`endif
      if (req_fire)
        tag_wr <= tag_wr + PW'(1);
      if (imem_rvalid)
        tag_rd <= tag_rd + PW'(1);
      if (redirect) begin
        fifo_wr <= '0;
        fifo_rd <= '0;
      end else begin
        fifo_wr <= fifo_wr + PW'(push);
        fifo_rd <= fifo_rd + PW'(pop);
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire)
      tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_inst[fifo_wr] <= imem_rdata;
      fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
    end
  end

  assign imem_addr  = fetch_pc;
  assign inst_valid = (fifo_count != '0);
  assign inst       = inst_valid ? fifo_inst[fifo_rd] : 32'h0;
  assign inst_pc    = inst_valid ? fifo_pc[fifo_rd] : 32'h0;
  assign pc_plus4   = inst_pc + 32'd4;

endmodule
